// File: rtl/seg7_scan_monitor_pkg.sv
// Shared constants, FSM encoding and frame helpers for the 7-segment scan monitor.
package seg7_scan_monitor_pkg;

  // Segment patterns, bit order abcdefg, active-high
  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;

  // Slot 5 is the rightmost digit (seconds ones) and is scanned first
  localparam logic [2:0] SLOT_FIRST = 3'd5;
  localparam logic [2:0] SLOT_LAST  = 3'd0;
  // Expected decimal point per slot: lit after hours, minutes and seconds ones
  localparam logic [5:0] DP_MASK    = 6'b101010;
  localparam logic [3:0] BCD_BAD    = 4'hF;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_CHECK   = 2'd2
  } state_e;

  // True when no digit of the frame is an unrecognised pattern
  function automatic logic frame_digits_ok(input logic [23:0] t);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (t[i*4 +: 4] == BCD_BAD) begin
        ok = 1'b0;
      end else begin
        ok = ok;
      end
    end
    return ok;
  endfunction

  // True when the frame {h10,h1,m10,m1,s10,s1} is a legal 24-hour time
  function automatic logic frame_in_range(input logic [23:0] t);
    logic [3:0] h10;
    logic [3:0] h1;
    logic [3:0] m10;
    logic [3:0] s10;
    h10 = t[23:20];
    h1  = t[19:16];
    m10 = t[15:12];
    s10 = t[7:4];
    return (h10 <= 4'd2) && !((h10 == 4'd2) && (h1 > 4'd3)) &&
           (m10 <= 4'd5) && (s10 <= 4'd5);
  endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational decode of one 7-segment pattern back to its BCD digit.
module seg7_to_bcd
  import seg7_scan_monitor_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] bcd
);

  // Map the ten legal digit patterns; anything else (blank included) is bad
  always_comb begin
    bcd = BCD_BAD;
    case (seg)
      SEG_0:   bcd = 4'd0;
      SEG_1:   bcd = 4'd1;
      SEG_2:   bcd = 4'd2;
      SEG_3:   bcd = 4'd3;
      SEG_4:   bcd = 4'd4;
      SEG_5:   bcd = 4'd5;
      SEG_6:   bcd = 4'd6;
      SEG_7:   bcd = 4'd7;
      SEG_8:   bcd = 4'd8;
      SEG_9:   bcd = 4'd9;
      default: bcd = BCD_BAD;
    endcase
  end

endmodule

// File: rtl/seg7_scan_monitor.sv
// Monitors a multiplexed 7-segment scan, rebuilds HH:MM:SS frames and checks them.
module seg7_scan_monitor
  import seg7_scan_monitor_pkg::*;
#(
  parameter int STABLE_CYC = 4,
  parameter int CNT_W      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  seg7_sel,
  input  logic [6:0]  seg7_out,
  input  logic        dpt,
  output logic [23:0] time_bcd,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        sec_tick,
  output logic        locked
);

  localparam logic [CNT_W-1:0] CAP_CNT = CNT_W'(STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [2:0]       sel_prev_r;
  logic [CNT_W-1:0] stab_cnt_r;
  logic             captured_r;
  logic             sel_same_s;
  logic             capture_s;
  logic [3:0]       bcd_s;

  logic [3:0]       digit_r [0:5];
  logic [5:0]       dp_r;
  logic [23:0]      frame_s;
  logic             check_ok_s;

  state_e           state_r;
  state_e           next_state_s;
  logic [2:0]       exp_sel_r;
  logic [2:0]       exp_sel_nxt_s;
  logic             seq_ok_s;

  logic [23:0]      time_nxt_s;
  logic             valid_nxt_s;
  logic             err_nxt_s;
  logic             tick_nxt_s;
  logic             locked_nxt_s;

  seg7_to_bcd u_dec (
    .seg (seg7_out),
    .bcd (bcd_s)
  );

  // A slot change in the capture cycle wins: sel_same_s gates the capture
  assign sel_same_s = (seg7_sel == sel_prev_r);
  assign capture_s  = sel_same_s && (stab_cnt_r == CAP_CNT) && !captured_r;
  assign seq_ok_s   = (seg7_sel == exp_sel_r) && (seg7_sel <= SLOT_FIRST);

  assign frame_s    = {digit_r[0], digit_r[1], digit_r[2],
                       digit_r[3], digit_r[4], digit_r[5]};
  assign check_ok_s = frame_digits_ok(frame_s) && (dp_r == DP_MASK) &&
                      frame_in_range(frame_s);

  // Stability filter: restart on any slot change, count while the slot holds
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_prev_r <= SLOT_FIRST;
      stab_cnt_r <= {CNT_W{1'b0}};
      captured_r <= 1'b0;
    end else if (!sel_same_s) begin
      sel_prev_r <= seg7_sel;
      stab_cnt_r <= {CNT_W{1'b0}};
      captured_r <= 1'b0;
    end else begin
      if (stab_cnt_r != CNT_MAX) begin
        stab_cnt_r <= stab_cnt_r + CNT_ONE;
      end
      if (capture_s) begin
        captured_r <= 1'b1;
      end
    end
  end

  // Slot storage: one decoded digit and decimal point per captured slot
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 6; i++) begin
        digit_r[i] <= BCD_BAD;
      end
      dp_r <= 6'b000000;
    end else if (capture_s && (seg7_sel <= SLOT_FIRST)) begin
      digit_r[seg7_sel] <= bcd_s;
      dp_r[seg7_sel]    <= dpt;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_HUNT;
      exp_sel_r <= SLOT_FIRST;
    end else begin
      state_r   <= next_state_s;
      exp_sel_r <= exp_sel_nxt_s;
    end
  end

  // FSM next state: hunt for slot 5, walk slots 5..0 in order, then check once
  always_comb begin
    next_state_s  = state_r;
    exp_sel_nxt_s = exp_sel_r;
    case (state_r)
      ST_HUNT: begin
        if (capture_s && (seg7_sel == SLOT_FIRST)) begin
          next_state_s  = ST_COLLECT;
          exp_sel_nxt_s = SLOT_FIRST - 3'd1;
        end else begin
          next_state_s  = ST_HUNT;
        end
      end
      ST_COLLECT: begin
        if (!capture_s) begin
          next_state_s = ST_COLLECT;
        end else if (!seq_ok_s) begin
          next_state_s = ST_HUNT;
        end else if (seg7_sel == SLOT_LAST) begin
          next_state_s = ST_CHECK;
        end else begin
          exp_sel_nxt_s = exp_sel_r - 3'd1;
        end
      end
      ST_CHECK: begin
        next_state_s  = ST_COLLECT;
        exp_sel_nxt_s = SLOT_FIRST;
      end
      default: begin
        next_state_s  = ST_HUNT;
        exp_sel_nxt_s = SLOT_FIRST;
      end
    endcase
  end

  // FSM outputs: next values of the registered strobes, lock flag and time
  always_comb begin
    time_nxt_s   = time_bcd;
    valid_nxt_s  = 1'b0;
    err_nxt_s    = 1'b0;
    tick_nxt_s   = 1'b0;
    locked_nxt_s = locked;
    case (state_r)
      ST_HUNT: begin
        locked_nxt_s = locked;
      end
      ST_COLLECT: begin
        if (capture_s && !seq_ok_s) begin
          err_nxt_s    = 1'b1;
          locked_nxt_s = 1'b0;
        end else begin
          locked_nxt_s = locked;
        end
      end
      ST_CHECK: begin
        if (check_ok_s) begin
          time_nxt_s   = frame_s;
          valid_nxt_s  = 1'b1;
          locked_nxt_s = 1'b1;
          // First frame after losing lock always ticks
          tick_nxt_s   = !locked || (frame_s[3:0] != time_bcd[3:0]);
        end else begin
          err_nxt_s    = 1'b1;
          locked_nxt_s = 1'b0;
        end
      end
      default: begin
        locked_nxt_s = 1'b0;
      end
    endcase
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      time_bcd    <= 24'h000000;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      sec_tick    <= 1'b0;
      locked      <= 1'b0;
    end else begin
      time_bcd    <= time_nxt_s;
      frame_valid <= valid_nxt_s;
      frame_err   <= err_nxt_s;
      sec_tick    <= tick_nxt_s;
      locked      <= locked_nxt_s;
    end
  end

endmodule

// File: tb/tb_seg7_scan_monitor.sv
// Scoreboard bench for seg7_scan_monitor: directed scans, queued expectations.
module tb_seg7_scan_monitor;

  logic        clk;
  logic        reset;
  logic [2:0]  seg7_sel;
  logic [6:0]  seg7_out;
  logic        dpt;
  logic [23:0] time_bcd;
  logic        frame_valid;
  logic        frame_err;
  logic        sec_tick;
  logic        locked;

  typedef struct {
    logic        is_err;
    logic [23:0] t;
    logic        tick;
    logic        lck;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp;
  int   n_bad;
  logic [5:0] dp_tb;

  seg7_scan_monitor #(.STABLE_CYC(4), .CNT_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .seg7_sel    (seg7_sel),
    .seg7_out    (seg7_out),
    .dpt         (dpt),
    .time_bcd    (time_bcd),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .sec_tick    (sec_tick),
    .locked      (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1111110;
      4'd1:    return 7'b0110000;
      4'd2:    return 7'b1101101;
      4'd3:    return 7'b1111001;
      4'd4:    return 7'b0110011;
      4'd5:    return 7'b1011011;
      4'd6:    return 7'b1011111;
      4'd7:    return 7'b1110000;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input logic is_err, input logic [23:0] t,
                          input logic tick, input logic lck);
    exp_t e;
    e.is_err = is_err;
    e.t      = t;
    e.tick   = tick;
    e.lck    = lck;
    exp_q.push_back(e);
  endtask

  task automatic drive_slot(input logic [2:0] s, input logic [3:0] d,
                            input logic dp, input int cyc);
    seg7_sel = s;
    seg7_out = seg_of(d);
    dpt      = dp;
    repeat (cyc) @(posedge clk);
    #1;
  endtask

  // Full frame in scan order 5..0; blank_slot >= 0 shows a blank pattern there
  task automatic scan_frame(input logic [23:0] t, input int blank_slot);
    logic [3:0] d;
    for (int s = 5; s >= 0; s--) begin
      d = t[(5 - s) * 4 +: 4];
      if (s == blank_slot) d = 4'hF;
      drive_slot(3'(s), d, dp_tb[s], 16);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_time"},   time_bcd,    24'h000000);
    chk({tag, "_valid"},  {23'd0, frame_valid}, 24'd0);
    chk({tag, "_err"},    {23'd0, frame_err},   24'd0);
    chk({tag, "_tick"},   {23'd0, sec_tick},    24'd0);
    chk({tag, "_locked"}, {23'd0, locked},      24'd0);
  endtask

  // Monitor: every strobe pops one expectation and checks the published state
  always @(negedge clk) begin
    if (!reset && (frame_valid || frame_err)) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_strobe: actual valid=%b err=%b, required no strobe (t=%0t)",
                 frame_valid, frame_err, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("strobe_kind", {22'd0, frame_valid, frame_err}, {22'd0, !mon_e.is_err, mon_e.is_err});
        chk("time_bcd",    time_bcd, mon_e.t);
        chk("sec_tick",    {23'd0, sec_tick}, {23'd0, mon_e.tick});
        chk("locked",      {23'd0, locked},   {23'd0, mon_e.lck});
      end
    end
  end

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    dp_tb    = 6'b101010;
    reset    = 1'b1;
    seg7_sel = 3'd5;
    seg7_out = 7'b0000000;
    dpt      = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk);
    #1 reset = 1'b0;

    // First lock, seconds advance, repeated second
    push_exp(1'b0, 24'h123456, 1'b1, 1'b1);
    scan_frame(24'h123456, -1);
    push_exp(1'b0, 24'h123457, 1'b1, 1'b1);
    scan_frame(24'h123457, -1);
    push_exp(1'b0, 24'h123457, 1'b0, 1'b1);
    scan_frame(24'h123457, -1);

    // Hours out of range fails CHECK, time holds
    push_exp(1'b1, 24'h123457, 1'b0, 1'b0);
    scan_frame(24'h250000, -1);

    // Slot 3 skipped: error at slot 2 capture, then a clean frame relocks
    push_exp(1'b1, 24'h123457, 1'b0, 1'b0);
    drive_slot(3'd5, 4'd7, 1'b1, 16);
    drive_slot(3'd4, 4'd5, 1'b0, 16);
    drive_slot(3'd2, 4'd4, 1'b0, 16);
    push_exp(1'b0, 24'h235959, 1'b1, 1'b1);
    scan_frame(24'h235959, -1);

    // Slot 3 visit too short to capture: error at slot 2
    push_exp(1'b1, 24'h235959, 1'b0, 1'b0);
    drive_slot(3'd5, 4'd9, 1'b1, 16);
    drive_slot(3'd4, 4'd5, 1'b0, 16);
    drive_slot(3'd3, 4'd9, 1'b1, 3);
    drive_slot(3'd2, 4'd5, 1'b0, 16);
    drive_slot(3'd1, 4'd3, 1'b1, 16);
    drive_slot(3'd0, 4'd2, 1'b0, 16);

    // Blank digit in slot 1 fails CHECK
    push_exp(1'b1, 24'h235959, 1'b0, 1'b0);
    scan_frame(24'h235959, 1);

    // Reset mid-frame, resume at slot 2: no strobe until a fresh frame
    drive_slot(3'd5, 4'd3, 1'b1, 16);
    drive_slot(3'd4, 4'd0, 1'b0, 16);
    drive_slot(3'd3, 4'd2, 1'b1, 8);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("midreset");
    @(posedge clk);
    #1 reset = 1'b0;
    drive_slot(3'd2, 4'd0, 1'b0, 16);
    drive_slot(3'd1, 4'd1, 1'b1, 16);
    drive_slot(3'd0, 4'd0, 1'b0, 16);
    push_exp(1'b0, 24'h010203, 1'b1, 1'b1);
    scan_frame(24'h010203, -1);

    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("queue_drained", 24'(exp_q.size()), 24'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
